// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage MIPS-style pipeline: load-use and HI/LO
// multiply/divide interlocks, branch flush gating and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ID_Instr,
  input  logic [31:0] ID_EX_Instr,
  input  logic        BranchTaken,
  output logic        PC_WrEn,
  output logic        IF_ID_WrEn,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Busy,
  output logic [5:0]  MD_Cnt,
  output logic [15:0] Stall_Cnt
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    logic       load;
    logic       md;
    logic       md_div;
    logic       hilo;
    logic [4:0] rs;
    logic [4:0] rt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] funct;
    op       = instr[31:26];
    funct    = instr[5:0];
    d.rs     = instr[25:21];
    d.rt     = instr[20:16];
    d.load   = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
               (op == 6'h24) || (op == 6'h25);
    d.md     = (op == 6'h00) && (funct[5:2] == 4'b0110);
    d.md_div = d.md && funct[1];
    d.hilo   = (op == 6'h00) && (funct[5:2] == 4'b0100);
    return d;
  endfunction

  dec_t   id_dec;
  dec_t   ex_dec;
  state_e state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic lu_stall, md_stall, stall, busy;

  always_comb begin
    id_dec = decode(ID_Instr);
    ex_dec = decode(ID_EX_Instr);
  end

  assign busy = (state_q == BUSY);

  always_comb begin
    lu_stall = ex_dec.load && (ex_dec.rt != 5'd0) &&
               ((ex_dec.rt == id_dec.rs) || (ex_dec.rt == id_dec.rt));
    md_stall = (id_dec.md || id_dec.hilo) && (busy || ex_dec.md);
    stall    = lu_stall || md_stall;
  end

  // An MD op reaching ID/EX while BUSY is ignored: md_stall keeps it in ID.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ex_dec.md) begin
          state_d  = BUSY;
          md_cnt_d = ex_dec.md_div ? DIV_CNT : MULT_CNT;
        end
      end
      BUSY: begin
        if (md_cnt_q <= 6'd1) begin
          state_d  = IDLE;
          md_cnt_d = 6'd0;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = 6'd0;
      end
    endcase
  end

  // Overlapping load-use and MD stalls are still one stall cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      md_cnt_q    <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is held the pipeline is frozen and flushed regardless of inputs.
  always_comb begin
    if (!RST_N) begin
      PC_WrEn      = 1'b0;
      IF_ID_WrEn   = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      MD_Busy      = 1'b0;
    end else begin
      PC_WrEn      = !stall;
      IF_ID_WrEn   = !stall;
      IF_ID_Flush  = BranchTaken && !stall;
      ID_EX_Bubble = stall;
      MD_Busy      = busy;
    end
  end

  assign MD_Cnt    = md_cnt_q;
  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed vectors checked with
// immediate assertions; the bench models the ID/EX bubble itself.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] ID_Instr;
  logic [31:0] ID_EX_Instr;
  logic        BranchTaken;
  logic        PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Bubble, MD_Busy;
  logic [5:0]  MD_Cnt;
  logic [15:0] Stall_Cnt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] LW8      = 32'h8D08_0000; // lw $8
  localparam logic [31:0] LW0      = 32'h8D00_0000; // lw $0
  localparam logic [31:0] ADD_RS8  = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] ADD_RT8  = 32'h0128_4820; // add $9,$9,$8
  localparam logic [31:0] ADD_Z    = 32'h0000_4820; // add $9,$0,$0
  localparam logic [31:0] ADDI8    = 32'h2108_0000; // addi $8,$8,0
  localparam logic [31:0] MULT     = 32'h0109_0018; // mult $8,$9
  localparam logic [31:0] DIV      = 32'h0109_001A; // div $8,$9
  localparam logic [31:0] MFLO     = 32'h0000_5012;
  localparam logic [31:0] MFHI     = 32'h0000_5010;

  pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .ID_Instr(ID_Instr), .ID_EX_Instr(ID_EX_Instr),
    .BranchTaken(BranchTaken), .PC_WrEn(PC_WrEn), .IF_ID_WrEn(IF_ID_WrEn),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble), .MD_Busy(MD_Busy),
    .MD_Cnt(MD_Cnt), .Stall_Cnt(Stall_Cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_forced(input string tag);
    chk({tag, " pc_wren"},  {31'd0, PC_WrEn},      32'd0);
    chk({tag, " ifid_wren"},{31'd0, IF_ID_WrEn},   32'd0);
    chk({tag, " flush"},    {31'd0, IF_ID_Flush},  32'd1);
    chk({tag, " bubble"},   {31'd0, ID_EX_Bubble}, 32'd1);
    chk({tag, " md_busy"},  {31'd0, MD_Busy},      32'd0);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    logic [15:0] sc;

    // Reset with a load-use pattern present: outputs stay forced.
    RST_N = 1'b0; ID_EX_Instr = LW8; ID_Instr = ADD_RS8; BranchTaken = 1'b0;
    tick(); tick(); settle();
    chk_forced("rst");
    chk("rst md_cnt",    {26'd0, MD_Cnt}, 32'd0);
    chk("rst stall_cnt", {16'd0, Stall_Cnt}, 32'd0);

    tick(); RST_N = 1'b1; ID_EX_Instr = NOP; ID_Instr = NOP; settle();
    chk("idle pc_wren", {31'd0, PC_WrEn}, 32'd1);
    chk("idle bubble",  {31'd0, ID_EX_Bubble}, 32'd0);
    chk("idle flush",   {31'd0, IF_ID_Flush}, 32'd0);

    // Load-use on rs.
    ID_EX_Instr = LW8; ID_Instr = ADD_RS8; settle();
    chk("lu_rs pc_wren",   {31'd0, PC_WrEn}, 32'd0);
    chk("lu_rs ifid_wren", {31'd0, IF_ID_WrEn}, 32'd0);
    chk("lu_rs bubble",    {31'd0, ID_EX_Bubble}, 32'd1);
    tick(); ID_EX_Instr = NOP; settle();
    chk("lu_rs stall_cnt", {16'd0, Stall_Cnt}, 32'd1);
    chk("lu_rs released",  {31'd0, PC_WrEn}, 32'd1);

    // Load-use on rt.
    ID_EX_Instr = LW8; ID_Instr = ADD_RT8; settle();
    chk("lu_rt bubble", {31'd0, ID_EX_Bubble}, 32'd1);
    tick(); ID_EX_Instr = NOP; settle();
    chk("lu_rt stall_cnt", {16'd0, Stall_Cnt}, 32'd2);

    // Load into $0 and a non-load writer never stall.
    ID_EX_Instr = LW0; ID_Instr = ADD_Z; settle();
    chk("lw0 pc_wren", {31'd0, PC_WrEn}, 32'd1);
    chk("lw0 bubble",  {31'd0, ID_EX_Bubble}, 32'd0);
    ID_EX_Instr = ADDI8; ID_Instr = ADD_RS8; settle();
    chk("addi no stall", {31'd0, PC_WrEn}, 32'd1);
    tick(); settle();
    chk("no stall cnt", {16'd0, Stall_Cnt}, 32'd2);

    // Taken branch during a stall is not flushed until the stall clears.
    ID_EX_Instr = LW8; ID_Instr = ADD_RS8; BranchTaken = 1'b1; settle();
    chk("br stalled flush", {31'd0, IF_ID_Flush}, 32'd0);
    chk("br stalled pc",    {31'd0, PC_WrEn}, 32'd0);
    tick(); ID_EX_Instr = NOP; settle();
    chk("br flush", {31'd0, IF_ID_Flush}, 32'd1);
    chk("br pc",    {31'd0, PC_WrEn}, 32'd1);
    tick(); BranchTaken = 1'b0; ID_Instr = NOP; settle();
    chk("br stall_cnt", {16'd0, Stall_Cnt}, 32'd3);

    // mult in EX, mflo in ID: 1 + 4 stall cycles.
    ID_EX_Instr = MULT; ID_Instr = MFLO; settle();
    chk("mult stall",   {31'd0, ID_EX_Bubble}, 32'd1);
    chk("mult md_busy", {31'd0, MD_Busy}, 32'd0);
    tick(); ID_EX_Instr = NOP; settle();
    for (int k = 4; k >= 1; k--) begin
      chk($sformatf("mult cnt%0d", k),   {26'd0, MD_Cnt}, 32'(k));
      chk($sformatf("mult busy%0d", k),  {31'd0, MD_Busy}, 32'd1);
      chk($sformatf("mult stall%0d", k), {31'd0, ID_EX_Bubble}, 32'd1);
      tick(); settle();
    end
    chk("mult done busy",  {31'd0, MD_Busy}, 32'd0);
    chk("mult done cnt",   {26'd0, MD_Cnt}, 32'd0);
    chk("mult done pc",    {31'd0, PC_WrEn}, 32'd1);
    chk("mult stall_cnt",  {16'd0, Stall_Cnt}, 32'd8); // 3 earlier + 5
    tick(); ID_Instr = NOP; settle();

    // div with unrelated ID instruction: busy for exactly 32 cycles, no stall.
    ID_EX_Instr = DIV; ID_Instr = NOP; settle();
    chk("div issue pc", {31'd0, PC_WrEn}, 32'd1);
    tick(); ID_EX_Instr = NOP; ID_Instr = ADD_RS8; settle();
    chk("div cnt32", {26'd0, MD_Cnt}, 32'd32);
    busy_cycles = 0;
    guard = 0;
    while (MD_Busy && guard < 40) begin
      if (!PC_WrEn) busy_cycles = 1000;
      busy_cycles++;
      guard++;
      tick(); settle();
    end
    chk("div busy cycles", 32'(busy_cycles), 32'd32);
    chk("div stall_cnt",   {16'd0, Stall_Cnt}, 32'd8);

    // Second div: ignored MD op while BUSY, double stall, reset at 17.
    ID_EX_Instr = DIV; ID_Instr = NOP; settle();
    tick(); ID_EX_Instr = NOP; settle();
    guard = 0;
    while (MD_Cnt != 6'd20 && guard < 40) begin guard++; tick(); settle(); end
    chk("div2 reach20", {26'd0, MD_Cnt}, 32'd20);
    sc = Stall_Cnt;
    ID_EX_Instr = LW8; ID_Instr = MULT; settle(); // both lu and md stall
    chk("dual stall", {31'd0, ID_EX_Bubble}, 32'd1);
    tick(); ID_EX_Instr = NOP; ID_Instr = NOP; settle();
    chk("dual stall once", {16'd0, Stall_Cnt}, {16'd0, sc + 16'd1});
    chk("div2 cnt19", {26'd0, MD_Cnt}, 32'd19);
    tick(); ID_EX_Instr = MULT; settle(); // must not reload counter
    tick(); ID_EX_Instr = NOP; settle();
    chk("busy ignores md", {26'd0, MD_Cnt}, 32'd17);
    RST_N = 1'b0; ID_Instr = MFLO; ID_EX_Instr = LW8; BranchTaken = 1'b0; settle();
    chk_forced("mid rst");
    tick(); settle();
    chk("mid rst cnt",       {26'd0, MD_Cnt}, 32'd0);
    chk("mid rst stall_cnt", {16'd0, Stall_Cnt}, 32'd0);
    RST_N = 1'b1; ID_EX_Instr = NOP; settle();
    chk("post rst busy",  {31'd0, MD_Busy}, 32'd0);
    chk("post rst pc",    {31'd0, PC_WrEn}, 32'd1);

    // Stall counter saturates at 0xFFFF.
    ID_EX_Instr = LW8; ID_Instr = ADD_RS8; settle();
    repeat (65535) tick();
    settle();
    chk("sat reach", {16'd0, Stall_Cnt}, 32'h0000_FFFF);
    repeat (3) tick();
    settle();
    chk("sat hold", {16'd0, Stall_Cnt}, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_LAT, default 4, giving the busy cycles of the HI/LO unit for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_LAT, default 32, giving the busy cycles of the HI/LO unit for DIV/DIVU; legal range 1..63.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 CLK  input  1  clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-006 ID_Instr  input  32  instruction currently held in the IF/ID register.
REQ-007 ID_EX_Instr  input  32  instruction currently held in the ID/EX register.
REQ-008 BranchTaken  input  1  branch or jump in ID resolved as taken this cycle.
REQ-009 PC_WrEn  output  1  PC register load enable.
REQ-010 IF_ID_WrEn  output  1  IF/ID register load enable.
REQ-011 IF_ID_Flush  output  1  IF/ID loads 0x00000000 (NOP) on the next edge.
REQ-012 ID_EX_Bubble  output  1  ID/EX loads 0x00000000 (NOP) on the next edge.
REQ-013 MD_Busy  output  1  HI/LO unit busy (state BUSY).
REQ-014 MD_Cnt  output  6  remaining busy cycles.
REQ-015 Stall_Cnt  output  16  saturating count of stall cycles since reset.

Function
REQ-016 Field decode SHALL use op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
REQ-017 A load SHALL be op in {0x20,0x21,0x23,0x24,0x25}; an MD op SHALL be op=0 with funct in {0x18,0x19,0x1A,0x1B}; a HI/LO access SHALL be op=0 with funct in {0x10,0x11,0x12,0x13}.
REQ-018 lu_stall SHALL be 1 when ID_EX_Instr is a load, its rt!=0, and its rt equals the rs or the rt of ID_Instr.
REQ-019 md_stall SHALL be 1 when ID_Instr is an MD op or a HI/LO access, and either MD_Busy=1 or ID_EX_Instr is an MD op.
REQ-020 Stall SHALL equal lu_stall OR md_stall, evaluated combinationally in the same cycle.
REQ-021 Outputs SHALL be PC_WrEn=IF_ID_WrEn=!Stall, ID_EX_Bubble=Stall, and IF_ID_Flush=BranchTaken AND !Stall; stall has priority, so a stalled branch is re-evaluated next cycle.
REQ-022 The FSM SHALL have two states, IDLE and BUSY.
REQ-023 IDLE->BUSY SHALL occur when ID_EX_Instr is an MD op; MD_Cnt loads MULT_LAT for funct 0x18/0x19 and DIV_LAT for funct 0x1A/0x1B.
REQ-024 In BUSY, MD_Cnt SHALL decrement by 1 per cycle; the edge at which MD_Cnt=1 SHALL set MD_Cnt=0 and return to IDLE.
REQ-025 In BUSY, an MD op in ID_EX_Instr SHALL be ignored; it cannot occur legally because md_stall holds it in ID.
REQ-026 Stall_Cnt SHALL increment on each edge where Stall=1 and hold at 0xFFFF.
REQ-027 When lu_stall and md_stall are both 1, a single stall cycle SHALL be counted.

Reset
REQ-028 An edge with RST_N=0 SHALL set state=IDLE, MD_Cnt=0 and Stall_Cnt=0, aborting any BUSY operation.
REQ-029 While RST_N=0, outputs SHALL be forced to PC_WrEn=0, IF_ID_WrEn=0, IF_ID_Flush=1, ID_EX_Bubble=1 and MD_Busy=0, independent of the inputs.
REQ-030 In the first cycle after RST_N rises, the block SHALL behave per REQ-016..027 from IDLE.

Verification
REQ-031 Load-use: ID_EX=0x8D080000 (lw $8), ID=0x010A4820 (add $9,$8,$10) -> Stall=1 for 1 cycle, PC_WrEn=0, ID_EX_Bubble=1, Stall_Cnt 0->1.
REQ-032 $0 load: ID_EX=0x8D000000, ID=0x00004820 -> Stall=0, PC_WrEn=1.
REQ-033 mult then mflo: ID_EX=0x01090018, ID=0x00005012 -> stall in that cycle; MD_Cnt reads 4,3,2,1 on following cycles; stall holds until MD_Busy=0; Stall_Cnt=5.
REQ-034 div: ID_EX=0x0109001A -> MD_Cnt=32 next cycle, MD_Busy=1 for exactly 32 cycles; an unrelated ID_Instr sees no stall.
REQ-035 Branch vs stall: BranchTaken=1 during a load-use stall -> IF_ID_Flush=0; next cycle, with no stall -> IF_ID_Flush=1.
REQ-036 Reset mid-div: RST_N=0 at MD_Cnt=17 -> next cycle MD_Cnt=0, MD_Busy=0, Stall_Cnt=0; outputs forced per REQ-029 while low.
